wb_control_unit: RTL and testbench
==================================

Name: wb_control_unit

Overview:
- Writeback stage of the 3PA pipeline; it is the producer end of the register-file write port that the decode stage consumes (rf_we, WAddr, WData).
- Holds the MA/WB pipeline register and selects the writeback source. It also aligns and extends sub-word loads.
- Guarantees exactly one register-file write per retired instruction, even under stall, and keeps a retired-instruction counter.
- Also exports the WB-stage forwarding tap.

Parameters:
- DATA_W, 32, datapath/register width.
- RADDR_W, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- Clk  in  1  clock; everything updates on its rising edge.
- reset  in  1  synchronous active-high reset.
- iWB  in  3  WB control field: [0] RegWrite; [2:1] WBSel (00 ALU, 01 MEM, 10 PC+4, 11 IMM).
- iMemSize  in  2  load size: 00 word, 01 half, 10 byte.
- iMemSigned  in  1  sign-extend sub-word load.
- iRDS  in  RADDR_W  destination register.
- iALU  in  DATA_W  ALU result; bits [1:0] also give the byte offset for loads.
- iMEM  in  DATA_W  raw word read from data memory.
- iPC  in  DATA_W  instruction PC.
- iIM  in  DATA_W  immediate.
- iValid  in  1  instruction valid.
- i_NOT_FLUSH  in  1  instruction not squashed upstream.
- stall  in  1  hold the MA/WB register.
- flush  in  1  clear the MA/WB register to a bubble.
- rf_we  out  1  register-file write enable.
- WAddr  out  RADDR_W  register-file write address.
- WData  out  DATA_W  register-file write data.
- WBfwd_We  out  1  forwarding valid; equals rf_we.
- WBfwd_Rd  out  RADDR_W  forwarding register; equals WAddr.
- WBfwd_Data  out  DATA_W  forwarding data; equals WData.
- oRetired  out  CNT_W  count of retired valid instructions.
- oValid  out  1  registered valid of the instruction currently in WB.

Behaviour:
- MA/WB register:
  - Captures all i* inputs every cycle.
  - Priority: reset > flush > stall > load.
  - reset or flush: every register field is zero, which makes the stage a bubble.
  - stall (without flush): all fields hold.
- Commit condition: commit = rValid & rNOT_FLUSH & rWB[0] & (rRDS != 0) & ~wrote.
  - rf_we = commit, so register r0 is never written.
  - The register file writes on the next rising edge, so the write is visible to decode one cycle after the instruction enters WB.
- wrote flag:
  - Cleared on reset, on flush, and whenever a new instruction loads (no stall).
  - Set when commit is high and stall is high.
  - Effect: under a multi-cycle stall, rf_we pulses only in the first cycle.
- WData selection:
  - WBSel 00 → rALU; 01 → aligned load; 10 → rPC+4 (modulo 2^DATA_W); 11 → rIM.
- Load alignment, with off = rALU[1:0]:
  - Word: rMEM unchanged; off is ignored.
  - Half: rMEM[16*off[1]+:16]; off[0] is ignored.
  - Byte: rMEM[8*off+:8].
  - Extension: sign-extend if rMemSigned, otherwise zero-extend.
  - iMemSize 11 behaves as word.
- Retired counter:
  - Increments by 1 on each edge where rValid & rNOT_FLUSH & ~retired_once.
  - retired_once follows the same clear/set rules as wrote.
  - A valid instruction with RegWrite = 0 (for example a store) still counts.
  - Wraps from 2^CNT_W−1 to 0.
  - Cleared only by reset; flush does not clear it.
- Outputs are combinational from the registers only; there is no input→output combinational path.
  - After reset: rf_we = 0, WAddr = 0, WData = 0, oValid = 0, oRetired = 0.
- Simultaneous events:
  - flush together with stall → flush wins.
  - flush in the same cycle as a commit: the write still happens on that edge, and the register clears afterwards.
  - reset in mid-stall: everything clears, and no write is issued that cycle.

Decomposition:
- Shared package/defines:
  - WB field bit positions and WBSel encodings.
  - MemSize encodings.
  - `MAWB_WIDTH and the MAWB_* field slices, packed in the same style as the ID/EX bus.
- Register: the existing pipereg, instantiated with WIDTH `MAWB_WIDTH.
- One natural sub-module: load_align (combinational size/offset/sign extraction).
- The wrote/retired flags and the counter stay in the top module.

Test Plan:
- Reset, then a valid ALU op: WB=001, RDS=5, ALU=0x1234 → next cycle rf_we=1, WAddr=5, WData=0x1234; oRetired=1 on the following edge.
- Loads with MEM=0x80FF7F01:
  - byte signed, off 3 → WData=0xFFFFFF80.
  - half unsigned, off 2 → 0x000080FF.
  - byte unsigned, off 1 → 0x0000007F.
- Link and r0 writes:
  - WBSel=10, PC=0xFFFFFFFC → WData=0x00000000.
  - RDS=0 with RegWrite → rf_we=0, but oRetired still increments.
- Stall held 4 cycles with a committing instruction in WB → rf_we high in exactly one cycle; oRetired increments exactly once; WAddr/WData held.
- Squashed and flushed instructions:
  - i_NOT_FLUSH=0 or iValid=0 → no write, no count.
  - flush+stall in the same cycle → the next cycle is a bubble (rf_we=0, oValid=0).
- Counter wrap and reset:
  - Preload the counter to 0xFFFFFFFF, retire one → oRetired=0.
  - Synchronous reset mid-stall → all outputs 0 on the next edge.

Source files
------------

// File: rtl/wb_control_unit_pkg.sv
// Shared encodings for the writeback stage: WB control field layout,
// writeback source selects and load size codes.
package wb_control_unit_pkg;

    localparam int WB_W         = 3;
    localparam int WB_REGWRITE  = 0;
    localparam int WB_SEL_LSB   = 1;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_PC4 = 2'b10;
    localparam logic [1:0] WBSEL_IMM = 2'b11;

    localparam logic [1:0] MEMSIZE_WORD = 2'b00;
    localparam logic [1:0] MEMSIZE_HALF = 2'b01;
    localparam logic [1:0] MEMSIZE_BYTE = 2'b10;

endpackage

// File: rtl/wb_control_unit_load_align.sv
// Sub-word load extraction: picks the half/byte addressed by the low
// address bits and sign- or zero-extends it to the datapath width.
module wb_control_unit_load_align
    import wb_control_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] mem,
    output logic [DATA_W-1:0] data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = mem[{off[1], 4'b0000} +: 16];
        byte_v = mem[{off, 3'b000} +: 8];
        case (size)
            MEMSIZE_HALF: data = {{(DATA_W-16){sgn & half_v[15]}}, half_v};
            MEMSIZE_BYTE: data = {{(DATA_W-8){sgn & byte_v[7]}}, byte_v};
            default:      data = mem;
        endcase
    end

endmodule

// File: rtl/wb_control_unit_pipereg.sv
// Generic pipeline register: reset and flush clear to a bubble, stall holds.
module wb_control_unit_pipereg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (flush) begin
            data_d = '0;
        end else if (!stall) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/wb_control_unit.sv
// Writeback stage: MA/WB register, source select, one-shot register-file
// write per instruction and a retired-instruction counter.
module wb_control_unit
    import wb_control_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic [WB_W-1:0]    iWB,
    input  logic [1:0]         iMemSize,
    input  logic               iMemSigned,
    input  logic [RADDR_W-1:0] iRDS,
    input  logic [DATA_W-1:0]  iALU,
    input  logic [DATA_W-1:0]  iMEM,
    input  logic [DATA_W-1:0]  iPC,
    input  logic [DATA_W-1:0]  iIM,
    input  logic               iValid,
    input  logic               i_NOT_FLUSH,
    input  logic               stall,
    input  logic               flush,
    output logic               rf_we,
    output logic [RADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0]  WData,
    output logic               WBfwd_We,
    output logic [RADDR_W-1:0] WBfwd_Rd,
    output logic [DATA_W-1:0]  WBfwd_Data,
    output logic [CNT_W-1:0]   oRetired,
    output logic               oValid
);

    // MA/WB bus layout, LSB first, same packing style as the ID/EX bus.
    localparam int MAWB_NF     = 0;
    localparam int MAWB_VALID  = 1;
    localparam int MAWB_IM     = 2;
    localparam int MAWB_PC     = MAWB_IM + DATA_W;
    localparam int MAWB_MEM    = MAWB_PC + DATA_W;
    localparam int MAWB_ALU    = MAWB_MEM + DATA_W;
    localparam int MAWB_RDS    = MAWB_ALU + DATA_W;
    localparam int MAWB_SIGNED = MAWB_RDS + RADDR_W;
    localparam int MAWB_SIZE   = MAWB_SIGNED + 1;
    localparam int MAWB_WB     = MAWB_SIZE + 2;
    localparam int MAWB_WIDTH  = MAWB_WB + WB_W;

    logic [MAWB_WIDTH-1:0] mawb_d;
    logic [MAWB_WIDTH-1:0] mawb_q;

    assign mawb_d = {iWB, iMemSize, iMemSigned, iRDS, iALU, iMEM, iPC, iIM,
                     iValid, i_NOT_FLUSH};

    wb_control_unit_pipereg #(
        .WIDTH (MAWB_WIDTH)
    ) u_mawb (
        .clk   (Clk),
        .srst  (reset),
        .flush (flush),
        .stall (stall),
        .d     (mawb_d),
        .q     (mawb_q)
    );

    logic [WB_W-1:0]    r_wb;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [RADDR_W-1:0] r_rds;
    logic [DATA_W-1:0]  r_alu;
    logic [DATA_W-1:0]  r_mem;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_im;
    logic               r_valid;
    logic               r_nf;

    assign r_wb     = mawb_q[MAWB_WB +: WB_W];
    assign r_size   = mawb_q[MAWB_SIZE +: 2];
    assign r_signed = mawb_q[MAWB_SIGNED];
    assign r_rds    = mawb_q[MAWB_RDS +: RADDR_W];
    assign r_alu    = mawb_q[MAWB_ALU +: DATA_W];
    assign r_mem    = mawb_q[MAWB_MEM +: DATA_W];
    assign r_pc     = mawb_q[MAWB_PC +: DATA_W];
    assign r_im     = mawb_q[MAWB_IM +: DATA_W];
    assign r_valid  = mawb_q[MAWB_VALID];
    assign r_nf     = mawb_q[MAWB_NF];

    logic [DATA_W-1:0] load_data;

    wb_control_unit_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size (r_size),
        .sgn  (r_signed),
        .off  (r_alu[1:0]),
        .mem  (r_mem),
        .data (load_data)
    );

    logic             wrote_q, wrote_d;
    logic             retired_once_q, retired_once_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;
    logic             retire;
    logic [DATA_W-1:0] wdata;

    assign commit = r_valid & r_nf & r_wb[WB_REGWRITE] & (r_rds != '0) & ~wrote_q;
    assign retire = r_valid & r_nf & ~retired_once_q;

    always_comb begin
        case (r_wb[WB_SEL_LSB +: 2])
            WBSEL_MEM: wdata = load_data;
            WBSEL_PC4: wdata = r_pc + DATA_W'(4);
            WBSEL_IMM: wdata = r_im;
            default:   wdata = r_alu;
        endcase
    end

    // The one-shot flags only latch while the instruction is held by stall;
    // any new load or flush brings a fresh instruction and clears them.
    always_comb begin
        wrote_d        = 1'b0;
        retired_once_d = 1'b0;
        if (!flush && stall) begin
            wrote_d        = wrote_q | commit;
            retired_once_d = retired_once_q | retire;
        end
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            wrote_q        <= 1'b0;
            retired_once_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            wrote_q        <= wrote_d;
            retired_once_q <= retired_once_d;
            cnt_q          <= cnt_d;
        end
    end

    assign rf_we      = commit;
    assign WAddr      = r_rds;
    assign WData      = wdata;
    assign WBfwd_We   = commit;
    assign WBfwd_Rd   = r_rds;
    assign WBfwd_Data = wdata;
    assign oRetired   = cnt_q;
    assign oValid     = r_valid;

endmodule

// File: tb/tb_wb_control_unit.sv
// Bench for wb_control_unit: directed steps then random traffic, each cycle
// compared against an instruction-level model of the writeback stage.
module tb_wb_control_unit;

    logic        Clk = 1'b0;
    logic        reset, stall, flush;
    logic [2:0]  iWB;
    logic [1:0]  iMemSize;
    logic        iMemSigned;
    logic [4:0]  iRDS;
    logic [31:0] iALU, iMEM, iPC, iIM;
    logic        iValid, i_NOT_FLUSH;

    logic        rf_we, WBfwd_We, oValid;
    logic [4:0]  WAddr, WBfwd_Rd;
    logic [31:0] WData, WBfwd_Data, oRetired;

    logic        s_we, s_fwe, s_valid;
    logic [4:0]  s_waddr, s_frd;
    logic [31:0] s_wdata, s_fdata;
    logic [3:0]  s_retired;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    wb_control_unit dut (
        .Clk(Clk), .reset(reset), .iWB(iWB), .iMemSize(iMemSize),
        .iMemSigned(iMemSigned), .iRDS(iRDS), .iALU(iALU), .iMEM(iMEM),
        .iPC(iPC), .iIM(iIM), .iValid(iValid), .i_NOT_FLUSH(i_NOT_FLUSH),
        .stall(stall), .flush(flush), .rf_we(rf_we), .WAddr(WAddr),
        .WData(WData), .WBfwd_We(WBfwd_We), .WBfwd_Rd(WBfwd_Rd),
        .WBfwd_Data(WBfwd_Data), .oRetired(oRetired), .oValid(oValid)
    );

    // Narrow-counter copy driven identically, so wrap-around is reachable.
    wb_control_unit #(.CNT_W(4)) dut4 (
        .Clk(Clk), .reset(reset), .iWB(iWB), .iMemSize(iMemSize),
        .iMemSigned(iMemSigned), .iRDS(iRDS), .iALU(iALU), .iMEM(iMEM),
        .iPC(iPC), .iIM(iIM), .iValid(iValid), .i_NOT_FLUSH(i_NOT_FLUSH),
        .stall(stall), .flush(flush), .rf_we(s_we), .WAddr(s_waddr),
        .WData(s_wdata), .WBfwd_We(s_fwe), .WBfwd_Rd(s_frd),
        .WBfwd_Data(s_fdata), .oRetired(s_retired), .oValid(s_valid)
    );

    // Model: the instruction currently sitting in WB plus per-instruction history.
    typedef struct {
        logic [2:0]  wb;
        logic [1:0]  size;
        logic        sgn;
        logic [4:0]  rds;
        logic [31:0] alu, mem, pc, im;
        logic        valid, nf;
    } instr_t;

    instr_t      cur;
    bit          cur_written;
    bit          cur_counted;
    longint      retired_total;
    int          writes_seen;

    function automatic instr_t bubble();
        instr_t b;
        b.wb = 0; b.size = 0; b.sgn = 0; b.rds = 0;
        b.alu = 0; b.mem = 0; b.pc = 0; b.im = 0;
        b.valid = 0; b.nf = 0;
        return b;
    endfunction

    function automatic logic [31:0] load_value(instr_t x);
        int unsigned off = x.alu % 4;
        int unsigned v;
        if (x.size == 2'd1) begin
            v = (x.mem >> (16 * (off / 2))) & 32'hFFFF;
            if (x.sgn && v >= 32'h8000) v = v - 32'h10000;
        end else if (x.size == 2'd2) begin
            v = (x.mem >> (8 * off)) & 32'hFF;
            if (x.sgn && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = x.mem;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_data(instr_t x);
        case (x.wb[2:1])
            2'd0:    return x.alu;
            2'd1:    return load_value(x);
            2'd2:    return x.pc + 32'd4;
            default: return x.im;
        endcase
    endfunction

    function automatic bit exp_we();
        return cur.valid && cur.nf && cur.wb[0] && cur.rds != 0 && !cur_written;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [2:0] wb, input logic [1:0] size,
                             input logic sgn, input logic [4:0] rds,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [31:0] pc, input logic [31:0] im);
        iWB = wb; iMemSize = size; iMemSigned = sgn; iRDS = rds;
        iALU = alu; iMEM = mem; iPC = pc; iIM = im;
        iValid = 1'b1; i_NOT_FLUSH = 1'b1;
    endtask

    task automatic set_ctl(input logic r, input logic s, input logic f);
        reset = r; stall = s; flush = f;
    endtask

    // One clock: apply the edge to the model, then compare every output.
    task automatic tick(input string tag);
        instr_t incoming;
        bit     will_write, will_count;
        incoming.wb = iWB; incoming.size = iMemSize; incoming.sgn = iMemSigned;
        incoming.rds = iRDS; incoming.alu = iALU; incoming.mem = iMEM;
        incoming.pc = iPC; incoming.im = iIM; incoming.valid = iValid;
        incoming.nf = i_NOT_FLUSH;
        will_write = exp_we();
        will_count = cur.valid && cur.nf && !cur_counted;
        @(posedge Clk);
        if (reset) begin
            cur = bubble(); cur_written = 0; cur_counted = 0; retired_total = 0;
        end else begin
            if (will_write) writes_seen++;
            if (will_count) retired_total++;
            if (flush) begin
                cur = bubble(); cur_written = 0; cur_counted = 0;
            end else if (stall) begin
                cur_written = cur_written || will_write;
                cur_counted = cur_counted || will_count;
            end else begin
                cur = incoming; cur_written = 0; cur_counted = 0;
            end
        end
        @(negedge Clk);
        chk({tag, ".we"},    {31'd0, rf_we},    {31'd0, exp_we()});
        chk({tag, ".addr"},  {27'd0, WAddr},    {27'd0, cur.rds});
        chk({tag, ".data"},  WData,             exp_data(cur));
        chk({tag, ".valid"}, {31'd0, oValid},   {31'd0, cur.valid});
        chk({tag, ".ret"},   oRetired,          32'(retired_total));
        chk({tag, ".ret4"},  {28'd0, s_retired}, 32'(retired_total % 16));
        chk({tag, ".fwd"},   {WBfwd_Data[26:0], WBfwd_Rd},
                             {WData[26:0], WAddr});
        chk({tag, ".fwe"},   {31'd0, WBfwd_We}, {31'd0, rf_we});
    endtask

    initial begin
        int w0;
        cur = bubble(); cur_written = 0; cur_counted = 0;
        retired_total = 0; writes_seen = 0;
        set_instr(3'b000, 2'd0, 1'b0, 5'd0, 0, 0, 0, 0);
        iValid = 1'b0; i_NOT_FLUSH = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        tick("reset0");
        tick("reset1");
        chk("reset.we", {31'd0, rf_we}, 32'd0);
        chk("reset.ret", oRetired, 32'd0);

        set_ctl(1'b0, 1'b0, 1'b0);
        set_instr(3'b001, 2'd0, 1'b0, 5'd5, 32'h1234, 0, 0, 0);
        tick("alu");
        chk("alu.we", {31'd0, rf_we}, 32'd1);
        chk("alu.data", WData, 32'h0000_1234);
        chk("alu.ret_before", oRetired, 32'd0);

        set_instr(3'b011, 2'd2, 1'b1, 5'd6, 32'd3, 32'h80FF7F01, 0, 0);
        tick("lb_s3");
        chk("alu.ret_after", oRetired, 32'd1);
        chk("lb_s3.data", WData, 32'hFFFF_FF80);
        set_instr(3'b011, 2'd1, 1'b0, 5'd7, 32'd2, 32'h80FF7F01, 0, 0);
        tick("lh_u2");
        chk("lh_u2.data", WData, 32'h0000_80FF);
        set_instr(3'b011, 2'd2, 1'b0, 5'd8, 32'd1, 32'h80FF7F01, 0, 0);
        tick("lb_u1");
        chk("lb_u1.data", WData, 32'h0000_007F);
        set_instr(3'b101, 2'd0, 1'b0, 5'd1, 0, 0, 32'hFFFFFFFC, 0);
        tick("link");
        chk("link.data", WData, 32'h0000_0000);
        set_instr(3'b001, 2'd0, 1'b0, 5'd0, 32'h55, 0, 0, 0);
        tick("r0");
        chk("r0.we", {31'd0, rf_we}, 32'd0);

        // Committing instruction held for four stall cycles.
        set_instr(3'b001, 2'd0, 1'b0, 5'd9, 32'hABCD, 0, 0, 0);
        w0 = writes_seen;
        tick("stall_ld");
        set_instr(3'b001, 2'd0, 1'b0, 5'd3, 32'h9999, 0, 0, 0);
        set_ctl(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick("stall");
        chk("stall.addr", {27'd0, WAddr}, 32'd9);
        chk("stall.data", WData, 32'h0000_ABCD);
        set_ctl(1'b0, 1'b0, 1'b0);
        set_instr(3'b000, 2'd0, 1'b0, 5'd0, 0, 0, 0, 0);
        iValid = 1'b0;
        tick("stall_end");
        chk("stall.writes", 32'(writes_seen - w0), 32'd1);

        set_instr(3'b001, 2'd0, 1'b0, 5'd4, 32'h11, 0, 0, 0);
        i_NOT_FLUSH = 1'b0;
        tick("squash");
        chk("squash.we", {31'd0, rf_we}, 32'd0);
        set_instr(3'b001, 2'd0, 1'b0, 5'd4, 32'h22, 0, 0, 0);
        iValid = 1'b0;
        tick("invalid");

        set_instr(3'b001, 2'd0, 1'b0, 5'd10, 32'h33, 0, 0, 0);
        tick("pre_flush");
        set_ctl(1'b0, 1'b1, 1'b1);
        tick("flush_stall");
        chk("flush.valid", {31'd0, oValid}, 32'd0);
        chk("flush.we", {31'd0, rf_we}, 32'd0);

        // Random traffic; the 4-bit counter instance wraps many times here.
        for (int i = 0; i < 300; i++) begin
            set_instr(3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
                      $urandom, $urandom, $urandom, $urandom);
            iValid = ($urandom_range(0, 9) != 0);
            i_NOT_FLUSH = ($urandom_range(0, 9) != 0);
            set_ctl(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            tick("rand");
        end

        // Reset in the middle of a stall on a committing instruction.
        set_ctl(1'b0, 1'b0, 1'b0);
        set_instr(3'b001, 2'd0, 1'b0, 5'd12, 32'h77, 0, 0, 0);
        tick("rst_ld");
        set_ctl(1'b0, 1'b1, 1'b0);
        tick("rst_stall");
        set_ctl(1'b1, 1'b1, 1'b0);
        tick("rst_mid");
        chk("rst_mid.we", {31'd0, rf_we}, 32'd0);
        chk("rst_mid.data", WData, 32'd0);
        chk("rst_mid.ret", oRetired, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
